// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: ByteSel encodings, FSM
// state type, byte-lane masks and small helpers for alignment, byte enables
// and store-lane replication.
package mem_access_stage_pkg;

    localparam logic [1:0] BSEL_WORD = 2'b00;
    localparam logic [1:0] BSEL_BYTE = 2'b01;
    localparam logic [1:0] BSEL_HALF = 2'b10;

    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    function automatic logic is_aligned(input logic [1:0] bsel, input logic [1:0] a);
        case (bsel)
            BSEL_BYTE: return 1'b1;
            BSEL_HALF: return ~a[0];
            default:   return (a == 2'b00);   // 11 behaves as word
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] bsel, input logic [1:0] a);
        case (bsel)
            BSEL_BYTE: return LANE_BYTE << a;
            BSEL_HALF: return LANE_HALF << a;
            default:   return LANE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] bsel, input logic [31:0] d);
        case (bsel)
            BSEL_BYTE: return {4{d[7:0]}};
            BSEL_HALF: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// load_align_ext: picks the addressed byte/halfword lane out of a read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
// Ports: rdata (read word), addr_lo (address bits [1:0]), bsel (ByteSel),
//        load_unsigned (1 = zero-extend), data (extended result).
module load_align_ext
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  bsel,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (bsel)
            BSEL_BYTE: data = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
            BSEL_HALF: data = {{16{~load_unsigned & half_lane[15]}}, half_lane};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage between EX/MEM and MEM/WB. Issues word/half/
// byte loads and stores over a request/ready handshake, stalls upstream while
// an access is outstanding and registers write-back data and control.
// Ports: Clk/Rst; EX/MEM inputs (Valid, ALUResult, StoreData, MemRead,
//        MemWrite, ByteSel, LoadUnsigned, RegWrite, MemToReg, WriteAddr);
//        memory side (MemReq, MemWe, MemAddr, MemBe, MemWData, MemReady,
//        MemRData); Stall; MEM/WB outputs (WB_*); AlignErr/BusErr pulses.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Valid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  ByteSel,
    input  logic        LoadUnsigned,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic [4:0]  WriteAddr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWData,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic        Stall,
    output logic        WB_Valid,
    output logic        WB_RegWrite,
    output logic        WB_MemToReg,
    output logic [4:0]  WB_WriteAddr,
    output logic [31:0] WB_ALUResult,
    output logic [31:0] WB_ReadData,
    output logic        AlignErr,
    output logic        BusErr
);

    localparam logic [9:0] TIMEOUT_M1 = 10'(TIMEOUT - 1);

    state_t      state;
    logic [9:0]  cnt;
    logic [31:0] addr_q;
    logic [1:0]  bsel_q;
    logic        uns_q, we_q, regwrite_q, memtoreg_q;
    logic [4:0]  waddr_q;
    logic [31:0] load_data;

    logic mem_op, aligned, start, timeout_hit;

    assign mem_op      = MemRead | MemWrite;
    assign aligned     = is_aligned(ByteSel, ALUResult[1:0]);
    assign start       = (state == ST_IDLE) & Valid & mem_op & aligned;
    assign timeout_hit = (state == ST_ACCESS) & ~MemReady & (cnt == TIMEOUT_M1);

    assign MemReq = (state == ST_ACCESS);
    assign MemWe  = MemReq & we_q;
    // Stall releases in the completing cycle (ready or timeout) so upstream
    // advances on the same edge the result is written; reset forces it low.
    assign Stall  = ~Rst & (start | (MemReq & ~MemReady & ~timeout_hit));

    load_align_ext u_load_align_ext (
        .rdata         (MemRData),
        .addr_lo       (addr_q[1:0]),
        .bsel          (bsel_q),
        .load_unsigned (uns_q),
        .data          (load_data)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            bsel_q       <= '0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            waddr_q      <= '0;
            MemAddr      <= '0;
            MemBe        <= '0;
            MemWData     <= '0;
            WB_Valid     <= 1'b0;
            WB_RegWrite  <= 1'b0;
            WB_MemToReg  <= 1'b0;
            WB_WriteAddr <= '0;
            WB_ALUResult <= '0;
            WB_ReadData  <= '0;
            AlignErr     <= 1'b0;
            BusErr       <= 1'b0;
        end else begin
            WB_Valid <= 1'b0;
            AlignErr <= 1'b0;
            BusErr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Valid) begin
                        if (start) begin
                            state      <= ST_ACCESS;
                            cnt        <= '0;
                            addr_q     <= ALUResult;
                            bsel_q     <= ByteSel;
                            uns_q      <= LoadUnsigned;
                            we_q       <= MemWrite;   // read+write resolves to store
                            regwrite_q <= RegWrite;
                            memtoreg_q <= MemToReg;
                            waddr_q    <= WriteAddr;
                            MemAddr    <= {ALUResult[31:2], 2'b00};
                            MemBe      <= byte_enables(ByteSel, ALUResult[1:0]);
                            MemWData   <= store_lanes(ByteSel, StoreData);
                        end else begin
                            // Non-memory op or misaligned access retires now;
                            // a misaligned one must not write the register file.
                            WB_Valid     <= 1'b1;
                            WB_RegWrite  <= RegWrite & ~mem_op;
                            WB_MemToReg  <= MemToReg;
                            WB_WriteAddr <= WriteAddr;
                            WB_ALUResult <= ALUResult;
                            WB_ReadData  <= '0;
                            AlignErr     <= mem_op;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (MemReady || timeout_hit) begin
                        state        <= ST_IDLE;
                        WB_Valid     <= 1'b1;
                        WB_RegWrite  <= regwrite_q & MemReady;
                        WB_MemToReg  <= memtoreg_q;
                        WB_WriteAddr <= waddr_q;
                        WB_ALUResult <= addr_q;
                        WB_ReadData  <= (MemReady & ~we_q) ? load_data : '0;
                        BusErr       <= ~MemReady;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Valid = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] StoreData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  ByteSel = '0;
    logic        LoadUnsigned = 1'b0;
    logic        RegWrite = 1'b0;
    logic        MemToReg = 1'b0;
    logic [4:0]  WriteAddr = '0;
    logic        MemReq, MemWe, Stall;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBe;
    logic        MemReady = 1'b0;
    logic [31:0] MemRData = '0;
    logic        WB_Valid, WB_RegWrite, WB_MemToReg;
    logic [4:0]  WB_WriteAddr;
    logic [31:0] WB_ALUResult, WB_ReadData;
    logic        AlignErr, BusErr;

    always #5 Clk = ~Clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Valid(Valid), .ALUResult(ALUResult),
        .StoreData(StoreData), .MemRead(MemRead), .MemWrite(MemWrite),
        .ByteSel(ByteSel), .LoadUnsigned(LoadUnsigned), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .WriteAddr(WriteAddr), .MemReq(MemReq),
        .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData),
        .MemReady(MemReady), .MemRData(MemRData), .Stall(Stall),
        .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
        .WB_WriteAddr(WB_WriteAddr), .WB_ALUResult(WB_ALUResult),
        .WB_ReadData(WB_ReadData), .AlignErr(AlignErr), .BusErr(BusErr)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        rd_dc;
        logic        aerr;
        logic        berr;
    } wb_t;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] alu, sdata;
        logic        mrd, mwr;
        logic [1:0]  bsel;
        logic        uns, rw, m2r;
        logic [4:0]  waddr;
        logic [31:0] mrdata;
        int          delay;
        logic        req, we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        rd_dc, aerr, exp_rw;
    } vec_t;

    wb_t  sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(
        input string name, input logic valid, input logic [31:0] alu, input logic [31:0] sdata,
        input logic mrd, input logic mwr, input logic [1:0] bsel, input logic uns,
        input logic rw, input logic m2r, input logic [4:0] waddr, input logic [31:0] mrdata,
        input int delay, input logic req, input logic we, input logic [31:0] maddr,
        input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rd,
        input logic rd_dc, input logic aerr, input logic exp_rw);
        vec_t v;
        v.name = name; v.valid = valid; v.alu = alu; v.sdata = sdata; v.mrd = mrd; v.mwr = mwr;
        v.bsel = bsel; v.uns = uns; v.rw = rw; v.m2r = m2r; v.waddr = waddr; v.mrdata = mrdata;
        v.delay = delay; v.req = req; v.we = we; v.maddr = maddr; v.be = be; v.wdata = wdata;
        v.rd = rd; v.rd_dc = rd_dc; v.aerr = aerr; v.exp_rw = exp_rw;
        return v;
    endfunction

    // Scoreboard consumer: every WB_Valid pops one expected record.
    always @(negedge Clk) begin : monitor
        wb_t e;
        if (!Rst) begin
            if (WB_Valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_wb", 32'(WB_Valid), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("wb_ctrl", 32'({WB_RegWrite, WB_MemToReg, WB_WriteAddr, AlignErr, BusErr}),
                          32'({e.rw, e.m2r, e.waddr, e.aerr, e.berr}));
                    check("wb_alu", WB_ALUResult, e.alu);
                    if (!e.rd_dc) check("wb_rdata", WB_ReadData, e.rd);
                end
            end else begin
                check("err_pulse_alone", 32'({AlignErr, BusErr}), 32'(0));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int nstall;
        Valid = v.valid; ALUResult = v.alu; StoreData = v.sdata; MemRead = v.mrd;
        MemWrite = v.mwr; ByteSel = v.bsel; LoadUnsigned = v.uns; RegWrite = v.rw;
        MemToReg = v.m2r; WriteAddr = v.waddr;
        if (v.valid) sb_q.push_back('{v.exp_rw, v.m2r, v.waddr, v.alu, v.rd, v.rd_dc, v.aerr, 1'b0});
        #1;
        nstall = Stall ? 1 : 0;
        check({v.name, "_stall_issue"}, 32'(Stall), 32'(v.req));
        check({v.name, "_req_idle"}, 32'(MemReq), 32'(0));
        @(posedge Clk); #1;
        if (v.req) begin
            check({v.name, "_memreq"}, 32'(MemReq), 32'(1));
            check({v.name, "_memwe"}, 32'(MemWe), 32'(v.we));
            check({v.name, "_memaddr"}, MemAddr, v.maddr);
            check({v.name, "_membe"}, 32'(MemBe), 32'(v.be));
            if (v.we) check({v.name, "_memwdata"}, MemWData, v.wdata);
            for (int i = 0; i < v.delay; i++) begin
                if (Stall) nstall++;
                @(posedge Clk); #1;
            end
            MemReady = 1'b1; MemRData = v.mrdata;
            #1;
            if (Stall) nstall++;
            check({v.name, "_stall_cycles"}, 32'(nstall), 32'(v.delay + 1));
            @(posedge Clk); #1;
            MemReady = 1'b0; MemRData = '0;
            check({v.name, "_req_done"}, 32'(MemReq), 32'(0));
        end
        Valid = 1'b0;
    endtask

    initial begin
        int nreq;
        //        name   vld alu           sdata         rd wr bsel       uns rw m2r wa mrdata        dly req we maddr        be       wdata         rd            dc aerr erw
        vecs.push_back(mk("alu",   1, 32'h0000_1234, 32'h0,        0, 0, BSEL_WORD, 0, 1, 0, 5, 32'h0,        0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk("lb",    1, 32'h0000_0103, 32'h0,        1, 0, BSEL_BYTE, 0, 1, 1, 3, 32'h80FF_FF7F, 3, 1, 0, 32'h100,     4'b1000, 32'h0,        32'hFFFF_FF80, 0, 0, 1));
        vecs.push_back(mk("lbu",   1, 32'h0000_0103, 32'h0,        1, 0, BSEL_BYTE, 1, 1, 1, 4, 32'h80FF_FF7F, 0, 1, 0, 32'h100,     4'b1000, 32'h0,        32'h0000_0080, 0, 0, 1));
        vecs.push_back(mk("sh",    1, 32'h0000_0202, 32'hDEAD_BEEF, 0, 1, BSEL_HALF, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h200,     4'b1100, 32'hBEEF_BEEF, 32'h0,        1, 0, 0));
        vecs.push_back(mk("lw_mis",1, 32'h0000_0102, 32'h0,        1, 0, BSEL_WORD, 0, 1, 1, 9, 32'h0,        0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 1, 0));
        vecs.push_back(mk("lh",    1, 32'h0000_00FE, 32'h0,        1, 0, BSEL_HALF, 0, 1, 1, 10,32'h8001_1234, 1, 1, 0, 32'h0FC,     4'b1100, 32'h0,        32'hFFFF_8001, 0, 0, 1));
        vecs.push_back(mk("lhu",   1, 32'h0000_00FC, 32'h0,        1, 0, BSEL_HALF, 1, 1, 1, 11,32'h1234_F00D, 0, 1, 0, 32'h0FC,     4'b0011, 32'h0,        32'h0000_F00D, 0, 0, 1));
        vecs.push_back(mk("lw",    1, 32'h0000_0400, 32'h0,        1, 0, BSEL_WORD, 0, 1, 1, 12,32'hCAFE_BABE, 2, 1, 0, 32'h400,     4'b1111, 32'h0,        32'hCAFE_BABE, 0, 0, 1));
        vecs.push_back(mk("sb",    1, 32'h0000_0301, 32'h1234_56A5, 0, 1, BSEL_BYTE, 0, 0, 0, 0, 32'h0,        0, 1, 1, 32'h300,     4'b0010, 32'hA5A5_A5A5, 32'h0,        1, 0, 0));
        vecs.push_back(mk("lh_mis",1, 32'h0000_0101, 32'h0,        1, 0, BSEL_HALF, 0, 1, 0, 13,32'h0,        0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 1, 0));
        vecs.push_back(mk("bubble",0, 32'h0000_0800, 32'h0,        1, 0, BSEL_WORD, 0, 1, 1, 14,32'h0,        0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 0, 0));
        vecs.push_back(mk("rdwr",  1, 32'h0000_0500, 32'h1122_3344, 1, 1, 2'b11,     0, 1, 0, 15,32'hFFFF_FFFF, 1, 1, 1, 32'h500,     4'b1111, 32'h1122_3344, 32'h0,        1, 0, 1));
        vecs.push_back(mk("w11_mis",1,32'h0000_0502, 32'h0,        1, 0, 2'b11,     0, 1, 0, 16,32'h0,        0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 1, 0));
        vecs.push_back(mk("lb_pos",1, 32'h0000_0004, 32'h0,        1, 0, BSEL_BYTE, 0, 1, 1, 17,32'hAAAA_AA7F, 0, 1, 0, 32'h004,     4'b0001, 32'h0,        32'h0000_007F, 0, 0, 1));

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_req_we_stall", 32'({MemReq, MemWe, Stall}), 32'(0));
        check("rst_mem_regs", MemAddr | MemWData | 32'(MemBe), 32'(0));
        check("rst_wb_ctrl", 32'({WB_Valid, WB_RegWrite, WB_MemToReg, WB_WriteAddr, AlignErr, BusErr}), 32'(0));
        check("rst_wb_data", WB_ALUResult | WB_ReadData, 32'(0));
        Rst = 1'b0;
        @(posedge Clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);
        @(posedge Clk); #1;

        // MemReady while idle must be ignored
        MemReady = 1'b1; MemRData = 32'h1357_9BDF;
        repeat (2) @(posedge Clk);
        #1;
        check("ready_idle_req", 32'(MemReq), 32'(0));
        MemReady = 1'b0; MemRData = '0;
        @(posedge Clk); #1;

        // Timeout: no MemReady ever
        Valid = 1'b1; ALUResult = 32'h600; MemRead = 1'b1; MemWrite = 1'b0;
        ByteSel = BSEL_WORD; RegWrite = 1'b1; MemToReg = 1'b1; WriteAddr = 5'd7;
        sb_q.push_back('{1'b0, 1'b1, 5'd7, 32'h600, 32'h0, 1'b1, 1'b0, 1'b1});
        @(posedge Clk); #1;
        nreq = 0;
        for (int i = 0; i < 10 && MemReq; i++) begin
            nreq++;
            @(posedge Clk); #1;
        end
        Valid = 1'b0;
        check("timeout_req_cycles", 32'(nreq), 32'(TO));
        check("timeout_idle", 32'(MemReq), 32'(0));
        @(posedge Clk); #1;

        // Reset during the second ACCESS cycle
        Valid = 1'b1; ALUResult = 32'h700; MemRead = 1'b1; MemWrite = 1'b0;
        ByteSel = BSEL_WORD; RegWrite = 1'b1; WriteAddr = 5'd8;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("rstmid_pre_req", 32'(MemReq), 32'(1));
        Rst = 1'b1;
        #1;
        check("rstmid_req_stall", 32'({MemReq, Stall}), 32'(0));
        check("rstmid_wb_valid", 32'(WB_Valid), 32'(0));
        Valid = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("rstmid_after", 32'({WB_Valid, AlignErr, BusErr, MemReq}), 32'(0));
        end

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge Clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the pipelined CPU, sitting between the EX/MEM stage register and the MEM/WB stage register. Takes the ALU result, store data and memory control bits produced by execute, and performs word, halfword or byte loads and stores against a data memory with a ready handshake. Stalls the upstream pipeline while an access is outstanding, and presents registered write-back data and control to the next stage.

## Interface
- TIMEOUT, 255: max cycles to wait for MemReady before aborting an access (1..1023)
- Clk  in  1  pipeline clock (divided clock domain)
- Rst  in  1  asynchronous, active-high reset
- Valid  in  1  EX/MEM slot holds a real instruction
- ALUResult  in  32  effective address or ALU value
- StoreData  in  32  store source (RF_RD2 after forwarding)
- MemRead, MemWrite  in  1  load / store request
- ByteSel  in  2  00 word, 01 byte, 10 halfword, 11 treated as word
- LoadUnsigned  in  1  zero-extend sub-word loads when 1, sign-extend when 0
- RegWrite, MemToReg  in  1  write-back control, passed through
- WriteAddr  in  5  destination register, passed through
- MemReq  out  1  memory request, held until MemReady
- MemWe  out  1  1 = store
- MemAddr  out  32  word-aligned address ({ALUResult[31:2],2'b00})
- MemBe  out  4  byte enables
- MemWData  out  32  store data replicated into lanes
- MemReady  in  1  memory completes access this cycle
- MemRData  in  32  read word, valid when MemReady
- Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- WB_Valid, WB_RegWrite, WB_MemToReg  out  1  registered to MEM/WB
- WB_WriteAddr  out  5  registered
- WB_ALUResult, WB_ReadData  out  32  registered; ReadData already extended
- AlignErr, BusErr  out  1  one-cycle exception pulses

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, Valid and neither MemRead nor MemWrite: register passthrough; WB_Valid=1 next edge; Stall=0.
- IDLE, Valid with memory op, aligned: Stall=1 combinationally; next edge -> ACCESS, latch address, BE, wdata, control; timeout counter cleared.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00; byte always aligned. Misaligned: no request, stay IDLE, AlignErr pulse next edge, WB_Valid=1 with WB_RegWrite=0.
- ACCESS: MemReq=1, Stall=1. On MemReady: capture and extend MemRData lane, WB_* written, -> IDLE, Stall drops that same cycle (combinational on MemReady).
- Timeout: counter reaches TIMEOUT without MemReady -> IDLE, BusErr pulse, WB_RegWrite=0, WB_Valid=1.
- Byte enables: byte 4'b0001<<addr[1:0]; halfword 4'b0011<<addr[1:0]; word 4'b1111. Store data: byte {4{d[7:0]}}, halfword {2{d[15:0]}}, word d.
- Load extract: lane selected by addr[1:0]; extend to 32 per LoadUnsigned.
- MemRead and MemWrite both set: treated as store.
- Valid=0: bubble, WB_Valid=0 next edge, no request.

## Timing
- Reset (async): state IDLE; MemReq, MemWe, Stall, all WB_* outputs, AlignErr, BusErr = 0; MemAddr, MemBe, MemWData = 0; counter 0.
- Non-memory op latency: 1 cycle to WB_*.
- Memory op latency: 1 + N cycles, N = cycles in ACCESS until MemReady (minimum 2 total).
- Inputs sampled only in IDLE; upstream must hold them while Stall=1.
- MemReady outside ACCESS is ignored.
- Reset mid-ACCESS: request dropped immediately, no WB or error output.

## Structure
- Shared package: ByteSel encodings (BSEL_WORD/BYTE/HALF), FSM state enum, lane-mask constants.
- Sub-module: load_align_ext (combinational lane select plus sign/zero extension), reused by future load-forwarding logic.

## Test plan
- ALU op, ALUResult=0x0000_1234, RegWrite=1, WriteAddr=5 -> next edge WB_ALUResult=0x1234, WB_Valid=1, Stall never high.
- lb addr 0x103, MemRData=0x80FF_FF7F ready after 3 cycles -> MemBe=0001-style request, Stall 4 cycles, WB_ReadData=0xFFFF_FF80; with LoadUnsigned=1 -> 0x0000_0080.
- sh addr 0x202, StoreData=0xDEAD_BEEF -> MemAddr=0x200, MemBe=1100, MemWData=0xBEEF_BEEF, MemWe=1.
- lw addr 0x102 -> no MemReq, AlignErr pulse, WB_RegWrite=0.
- TIMEOUT=4, MemReady never asserted -> MemReq 4 cycles, BusErr pulse, return to IDLE.
- Rst asserted in 2nd ACCESS cycle -> MemReq and Stall low immediately, WB_Valid stays 0.
